// File: rtl/if_id_skid.sv
// rtl/if_id_skid.sv - IF/ID pipeline stage with valid/ready handshake, 1-entry skid, flush/halt and counters
module if_id_skid #(
    parameter int                 DATA_W    = 32,
    parameter int                 HITPOS_W  = 3,
    parameter int                 NUM_FLUSH = 4,
    parameter logic [DATA_W-1:0]  HALT_INS  = 'h0000_000C,
    parameter int                 CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_FLUSH-1:0] flush,
    input  logic                 halt,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    Ins_i,
    input  logic [DATA_W-1:0]    PC_i,
    input  logic [DATA_W-1:0]    prepc_i,
    input  logic [HITPOS_W-1:0]  hitpos_i,
    input  logic                 hit_i,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    Ins_o,
    output logic [DATA_W-1:0]    PC_o,
    output logic [DATA_W-1:0]    prepc_o,
    output logic [HITPOS_W-1:0]  hitpos_o,
    output logic                 hit_o,
    output logic                 skid_full,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    typedef enum logic [1:0] {S_EMPTY, S_FULL, S_SKID} state_t;

    typedef struct packed {
        logic [DATA_W-1:0]   ins;
        logic [DATA_W-1:0]   pc;
        logic [DATA_W-1:0]   prepc;
        logic [HITPOS_W-1:0] hitpos;
        logic                hit;
    } beat_t;

    state_t            state_q, state_d;
    beat_t             main_q, main_d;
    beat_t             skid_q, skid_d;
    beat_t             new_beat;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              accept;
    logic              flush_any;

    assign flush_any = |flush;
    assign accept    = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush_any) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: if (accept) state_d = S_FULL;
                S_FULL: begin
                    if (out_ready && !accept)      state_d = S_EMPTY;
                    else if (!out_ready && accept) state_d = S_SKID;
                end
                S_SKID:  if (out_ready) state_d = S_FULL;
                default: state_d = S_EMPTY;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state_q != S_SKID);
        out_valid = (state_q != S_EMPTY);
        skid_full = (state_q == S_SKID);
    end

    // main_q is kept all-zero whenever the stage is empty so a bubble decodes as a NOP
    always_comb begin
        new_beat = '{ins: (halt ? HALT_INS : Ins_i), pc: PC_i, prepc: prepc_i,
                     hitpos: hitpos_i, hit: hit_i};
        main_d   = main_q;
        skid_d   = skid_q;
        if (flush_any) begin
            main_d = '0;
            skid_d = '0;
        end else begin
            case (state_q)
                S_EMPTY: if (accept) main_d = new_beat;
                S_FULL: begin
                    if (out_ready)   main_d = accept ? new_beat : '0;
                    else if (accept) skid_d = new_beat;
                end
                S_SKID: begin
                    if (out_ready) begin
                        main_d = skid_q;
                        skid_d = '0;
                    end
                end
                default: begin
                    main_d = '0;
                    skid_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush_any && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    assign Ins_o     = main_q.ins;
    assign PC_o      = main_q.pc;
    assign prepc_o   = main_q.prepc;
    assign hitpos_o  = main_q.hitpos;
    assign hit_o     = main_q.hit;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_if_id_skid.sv
// tb/tb_if_id_skid.sv - scoreboard testbench for if_id_skid
module tb_if_id_skid;

    localparam logic [31:0] HALT_INS = 32'h0000_000C;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        logic [31:0] prepc;
        logic [2:0]  hitpos;
        logic        hit;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  flush;
    logic        halt;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] Ins_i, PC_i, prepc_i;
    logic [2:0]  hitpos_i;
    logic        hit_i;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Ins_o, PC_o, prepc_o;
    logic [2:0]  hitpos_o;
    logic        hit_o;
    logic        skid_full;
    logic [3:0]  stall_cnt, flush_cnt;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    if_id_skid #(.DATA_W(32), .HITPOS_W(3), .NUM_FLUSH(4), .HALT_INS(HALT_INS), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .halt(halt),
        .in_valid(in_valid), .in_ready(in_ready),
        .Ins_i(Ins_i), .PC_i(PC_i), .prepc_i(prepc_i), .hitpos_i(hitpos_i), .hit_i(hit_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .Ins_o(Ins_o), .PC_o(PC_o), .prepc_o(prepc_o), .hitpos_o(hitpos_o), .hit_o(hit_o),
        .skid_full(skid_full), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected beat per delivery; bubbles must carry a zero payload
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_beat: got Ins=%h PC=%h expected no beat", Ins_o, PC_o);
            end else begin
                e = sb.pop_front();
                n_checks++;
                if (Ins_o !== e.ins || PC_o !== e.pc || prepc_o !== e.prepc ||
                    hitpos_o !== e.hitpos || hit_o !== e.hit) begin
                    n_fail++;
                    $display("FAIL beat: got %h/%h/%h/%h/%b expected %h/%h/%h/%h/%b",
                             Ins_o, PC_o, prepc_o, hitpos_o, hit_o,
                             e.ins, e.pc, e.prepc, e.hitpos, e.hit);
                end
            end
        end else if (!out_valid) begin
            chk("bubble_payload", {31'd0, |{Ins_o, PC_o, prepc_o, hitpos_o, hit_o}}, 32'd0);
        end
    end

    // One clock: book the accepted beat (or drop the stage contents on rst/flush), then step the edge
    task automatic tick();
        exp_t e;
        @(negedge clk);
        #1;
        if (rst || (|flush)) begin
            sb.delete();
        end else if (in_valid && in_ready) begin
            e.ins    = halt ? HALT_INS : Ins_i;
            e.pc     = PC_i;
            e.prepc  = prepc_i;
            e.hitpos = hitpos_i;
            e.hit    = hit_i;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [31:0] ins, input logic [31:0] pc);
        in_valid = 1'b1;
        Ins_i    = ins;
        PC_i     = pc;
        prepc_i  = pc + 32'd4;
        hitpos_i = pc[4:2];
        hit_i    = pc[2];
    endtask

    initial begin
        rst = 1'b1; flush = 4'b0; halt = 1'b0; out_ready = 1'b0;
        set_beat(32'h55, 32'h10);

        // reset with in_valid held high
        tick(); tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_Ins_o", Ins_o, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_stall_cnt", {28'd0, stall_cnt}, 32'd0);
        chk("rst_flush_cnt", {28'd0, flush_cnt}, 32'd0);

        // streaming with out_ready=1
        rst = 1'b0; out_ready = 1'b1;
        set_beat(32'h1, 32'h104);
        tick();
        chk("latency_out_valid", {31'd0, out_valid}, 32'd1);
        chk("latency_Ins_o", Ins_o, 32'h1);
        for (int i = 2; i <= 3; i++) begin
            set_beat(i, 32'h100 + 32'(4 * i));
            tick();
        end
        in_valid = 1'b0;
        tick(); tick();
        chk("stream_drained", {31'd0, out_valid}, 32'd0);
        chk("stream_stall_cnt", {28'd0, stall_cnt}, 32'd0);

        // skid fill and drain
        out_ready = 1'b0;
        set_beat(32'hA, 32'h200);
        tick();
        set_beat(32'hB, 32'h204);
        tick();
        chk("skid_full", {31'd0, skid_full}, 32'd1);
        chk("skid_in_ready", {31'd0, in_ready}, 32'd0);
        chk("skid_stall_1", {28'd0, stall_cnt}, 32'd1);
        in_valid = 1'b0;
        tick();
        chk("skid_stall_2", {28'd0, stall_cnt}, 32'd2);
        out_ready = 1'b1;
        tick();
        chk("drain_skid_empty", {31'd0, skid_full}, 32'd0);
        chk("drain_Ins_o_B", Ins_o, 32'hB);
        tick();
        chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
        chk("drain_stall_cnt", {28'd0, stall_cnt}, 32'd2);

        // flush while in SKID
        out_ready = 1'b0;
        set_beat(32'hA, 32'h300);
        tick();
        set_beat(32'hB, 32'h304);
        tick();
        in_valid = 1'b0; flush = 4'b0100;
        tick();
        flush = 4'b0;
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_skid_full", {31'd0, skid_full}, 32'd0);
        chk("flush_Ins_o", Ins_o, 32'd0);
        chk("flush_PC_o", PC_o, 32'd0);
        chk("flush_cnt_1", {28'd0, flush_cnt}, 32'd1);
        chk("flush_stall_cnt", {28'd0, stall_cnt}, 32'd4);
        out_ready = 1'b1;
        tick(); tick();

        // halt injection
        halt = 1'b1;
        set_beat(32'h8C21_0004, 32'h40);
        tick();
        chk("halt_Ins_o", Ins_o, 32'h0000_000C);
        chk("halt_PC_o", PC_o, 32'h40);
        chk("halt_prepc_o", prepc_o, 32'h44);
        halt = 1'b0; in_valid = 1'b0;
        tick();

        // stall counter saturation, then flush beats halt
        out_ready = 1'b0;
        set_beat(32'h77, 32'h500);
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        chk("stall_saturate", {28'd0, stall_cnt}, 32'd15);
        flush = 4'b0001; halt = 1'b1;
        set_beat(32'h99, 32'h600);
        tick();
        flush = 4'b0; halt = 1'b0; in_valid = 1'b0;
        chk("flush_halt_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_halt_Ins_o", Ins_o, 32'd0);
        chk("flush_cnt_2", {28'd0, flush_cnt}, 32'd2);
        chk("stall_held_on_flush", {28'd0, stall_cnt}, 32'd15);
        out_ready = 1'b1;
        tick(); tick();

        // reset mid-transfer with both entries occupied
        out_ready = 1'b0;
        set_beat(32'hC1, 32'h700);
        tick();
        set_beat(32'hC2, 32'h704);
        tick();
        chk("pre_rst_skid_full", {31'd0, skid_full}, 32'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_skid_full", {31'd0, skid_full}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_Ins_o", Ins_o, 32'd0);
        chk("mid_rst_stall_cnt", {28'd0, stall_cnt}, 32'd0);
        chk("mid_rst_flush_cnt", {28'd0, flush_cnt}, 32'd0);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
